alarm_control_fsm: RTL and testbench
====================================

// Module: alarm_control_fsm
// PURPOSE
// Control FSM of the anti-theft alarm; sits directly upstream of Timer. Decodes ignition/door sensors,
// selects delay from an on-chip reprogrammable interval table, drives Timer value/start_timer,
// consumes Timer expired/one_hz_enable, and produces siren and status LED outputs.
// PARAMETERS
// T_ARM_DEF    4'd6   default arming delay (s)
// T_DRV_DEF    4'd8   default driver-door entry delay (s)
// T_PAS_DEF    4'd15  default passenger-door entry delay (s)
// T_ALARM_DEF  4'd10  default siren-on interval (s)
// PORTS
// clock          in   1  system clock
// reset          in   1  synchronous, active-high
// ignition       in   1  1 = ignition on
// door_driver    in   1  1 = driver door open
// door_pass      in   1  1 = passenger door open
// reprogram      in   1  1-cycle pulse: write prog_val into table[prog_sel]
// prog_sel       in   2  0=ARM 1=DRV 2=PAS 3=ALARM
// prog_val       in   4  new interval; 0 stores the parameter default
// expired        in   1  from Timer
// one_hz_enable  in   1  from Timer, 1-cycle tick
// start_timer    out  1  to Timer, 1-cycle load pulse
// timer_value    out  4  to Timer value
// siren          out  1  siren drive
// status_led     out  1  status indicator
// state_dbg      out  3  current state encoding
// BEHAVIOUR
// - Reset: state=ARMED; table=defaults; start_timer=0, timer_value=0, siren=0, status_led=0.
// - States: ARMED=0 TRIGGER=1 SOUND=2 DISARMED=3 WAIT_OPEN=4 WAIT_CLOSE=5 ARMING=6; 7 -> ARMED next cycle.
// - All outputs registered. start_timer=1 and timer_value=interval set on the same edge as entry into a
//   timed state; start_timer=0 every other cycle.
// - expired ignored in any cycle where start_timer=1 (stale Timer flag).
// - Priority: reset > reprogram > ignition > door/expired events.
// - reprogram: table write; state->ARMED, start_timer=0, regardless of ignition (next cycle re-evaluates).
// - ignition=1 in any state except DISARMED -> DISARMED.
// - ARMED: door_driver -> TRIGGER, start T_DRV; else door_pass -> TRIGGER, start T_PAS (driver wins).
// - TRIGGER: expired -> SOUND, start T_ALARM. Doors ignored.
// - SOUND: expired & both doors closed -> ARMED; expired & any door open -> stay SOUND, restart T_ALARM.
// - DISARMED: ignition=0 -> WAIT_OPEN.
// - WAIT_OPEN: door_driver -> WAIT_CLOSE.
// - WAIT_CLOSE: both doors closed -> ARMING, start T_ARM.
// - ARMING: any door open -> WAIT_CLOSE (no timer pulse); expired -> ARMED.
// - siren=1 iff next state is SOUND (asserts same edge as state entry).
// - status_led: ARMED -> toggles on each one_hz_enable, cleared on ARMED entry; TRIGGER/SOUND -> 1;
//   else 0.
// - Table writes take effect for the next timer load; a running interval is unaffected.
// TESTING
// T1 reset, all inputs 0 -> state_dbg=0, outputs 0; 3 one_hz ticks -> status_led 1,0,1.
// T2 ARMED, door_driver=1 1 cycle -> next edge state=1, start_timer=1, timer_value=8; expired -> state=2,
//    timer_value=10, siren=1; expired, doors closed -> state=0, siren=0.
// T3 ARMED, door_driver & door_pass same cycle -> timer_value=8; with door_pass only -> 15.
// T4 SOUND with door_pass held at expired -> stays 2, start_timer=1, timer_value=10.
// T5 ignition 1 in TRIGGER -> DISARMED, siren=0; ignition 0 -> 4; door_driver 1 -> 5; doors 0 -> 6,
//    timer_value=6; door open mid-ARMING -> 5; close, expired -> 0.
// T6 reprogram sel=1 val=3 in SOUND -> ARMED; driver door -> timer_value=3; sel=1 val=0 -> reloads 8;
//    stale expired=1 while start_timer=1 -> no transition.

Source files
------------

// File: rtl/alarm_control_if.sv
// Purpose: bundles the sensor, reprogramming and Timer-side signals of the
//          anti-theft alarm control FSM into one interface.
// Signals:
//   ignition, door_driver, door_pass   vehicle sensors (1 = on / open)
//   reprogram, prog_sel[1:0], prog_val[3:0]  interval table write port
//   expired, one_hz_enable             status from the downstream Timer
//   start_timer, timer_value[3:0]      load command to the Timer
//   siren, status_led                  alarm outputs
//   state_dbg[2:0]                     current FSM state encoding
// Modports:
//   master  drives sensors / Timer status, observes FSM outputs
//   slave   the control FSM itself
interface alarm_control_if;
  logic       ignition;
  logic       door_driver;
  logic       door_pass;
  logic       reprogram;
  logic [1:0] prog_sel;
  logic [3:0] prog_val;
  logic       expired;
  logic       one_hz_enable;
  logic       start_timer;
  logic [3:0] timer_value;
  logic       siren;
  logic       status_led;
  logic [2:0] state_dbg;

  modport master (
    output ignition, door_driver, door_pass, reprogram, prog_sel, prog_val,
           expired, one_hz_enable,
    input  start_timer, timer_value, siren, status_led, state_dbg
  );

  modport slave (
    input  ignition, door_driver, door_pass, reprogram, prog_sel, prog_val,
           expired, one_hz_enable,
    output start_timer, timer_value, siren, status_led, state_dbg
  );
endinterface

// File: rtl/alarm_control_fsm.sv
// Purpose: control FSM of the anti-theft alarm. Decodes ignition and door
//          sensors, picks a delay from a small reprogrammable interval table,
//          loads the downstream Timer and drives the siren and status LED.
// Ports:
//   clock   system clock
//   reset   synchronous, active-high
//   bus     alarm_control_if.slave (sensors, table write port, Timer
//           handshake, siren/status_led/state_dbg outputs)
// All outputs are registered; start_timer/timer_value/siren change on the
// same edge as the state they belong to.
module alarm_control_fsm #(
  parameter logic [3:0] T_ARM_DEF   = 4'd6,
  parameter logic [3:0] T_DRV_DEF   = 4'd8,
  parameter logic [3:0] T_PAS_DEF   = 4'd15,
  parameter logic [3:0] T_ALARM_DEF = 4'd10
) (
  input  logic            clock,
  input  logic            reset,
  alarm_control_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_ARMED      = 3'd0,
    ST_TRIGGER    = 3'd1,
    ST_SOUND      = 3'd2,
    ST_DISARMED   = 3'd3,
    ST_WAIT_OPEN  = 3'd4,
    ST_WAIT_CLOSE = 3'd5,
    ST_ARMING     = 3'd6,
    ST_ILLEGAL    = 3'd7
  } state_t;

  localparam logic [1:0] SEL_ARM   = 2'd0;
  localparam logic [1:0] SEL_DRV   = 2'd1;
  localparam logic [1:0] SEL_PAS   = 2'd2;
  localparam logic [1:0] SEL_ALARM = 2'd3;

  function automatic logic [3:0] default_interval(input logic [1:0] sel);
    case (sel)
      SEL_ARM:   default_interval = T_ARM_DEF;
      SEL_DRV:   default_interval = T_DRV_DEF;
      SEL_PAS:   default_interval = T_PAS_DEF;
      default:   default_interval = T_ALARM_DEF;
    endcase
  endfunction

  state_t     state_q, state_d;
  logic       start_timer_q, start_timer_d;
  logic [3:0] timer_value_q, timer_value_d;
  logic       siren_q, siren_d;
  logic       status_led_q, status_led_d;
  logic [3:0] table_q [4];

  logic       expired_ok;
  logic       any_door;

  // Interval table. A zero write restores the default so the table can
  // never hold a zero-length interval.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        table_q[i] <= default_interval(i[1:0]);
      end
    end else if (bus.reprogram) begin
      table_q[bus.prog_sel] <= (bus.prog_val == 4'd0) ? default_interval(bus.prog_sel)
                                                      : bus.prog_val;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_ARMED;
      start_timer_q <= 1'b0;
      timer_value_q <= 4'd0;
      siren_q       <= 1'b0;
      status_led_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_timer_q <= start_timer_d;
      timer_value_q <= timer_value_d;
      siren_q       <= siren_d;
      status_led_q  <= status_led_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    start_timer_d = 1'b0;
    timer_value_d = timer_value_q;
    siren_d       = 1'b0;
    status_led_d  = 1'b0;

    // While our load pulse is on the wire the Timer's expired flag still
    // refers to the previous interval, so it must not be acted on.
    expired_ok = bus.expired && !start_timer_q;
    any_door   = bus.door_driver || bus.door_pass;

    if (bus.reprogram) begin
      state_d = ST_ARMED;
    end else if (bus.ignition && (state_q != ST_DISARMED)) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (bus.door_driver) begin
            state_d       = ST_TRIGGER;
            start_timer_d = 1'b1;
            timer_value_d = table_q[SEL_DRV];
          end else if (bus.door_pass) begin
            state_d       = ST_TRIGGER;
            start_timer_d = 1'b1;
            timer_value_d = table_q[SEL_PAS];
          end
        end
        ST_TRIGGER: begin
          if (expired_ok) begin
            state_d       = ST_SOUND;
            start_timer_d = 1'b1;
            timer_value_d = table_q[SEL_ALARM];
          end
        end
        ST_SOUND: begin
          if (expired_ok) begin
            if (any_door) begin
              start_timer_d = 1'b1;
              timer_value_d = table_q[SEL_ALARM];
            end else begin
              state_d = ST_ARMED;
            end
          end
        end
        ST_DISARMED: begin
          if (!bus.ignition) state_d = ST_WAIT_OPEN;
        end
        ST_WAIT_OPEN: begin
          if (bus.door_driver) state_d = ST_WAIT_CLOSE;
        end
        ST_WAIT_CLOSE: begin
          if (!any_door) begin
            state_d       = ST_ARMING;
            start_timer_d = 1'b1;
            timer_value_d = table_q[SEL_ARM];
          end
        end
        ST_ARMING: begin
          // A door reopening abandons the countdown; the Timer is simply
          // reloaded when the doors close again.
          if (any_door) begin
            state_d = ST_WAIT_CLOSE;
          end else if (expired_ok) begin
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_ARMED;
      endcase
    end

    siren_d = (state_d == ST_SOUND);

    case (state_d)
      ST_ARMED: begin
        if (state_q != ST_ARMED) begin
          status_led_d = 1'b0;
        end else if (bus.one_hz_enable) begin
          status_led_d = !status_led_q;
        end else begin
          status_led_d = status_led_q;
        end
      end
      ST_TRIGGER, ST_SOUND: status_led_d = 1'b1;
      default:              status_led_d = 1'b0;
    endcase
  end

  assign bus.start_timer = start_timer_q;
  assign bus.timer_value = timer_value_q;
  assign bus.siren       = siren_q;
  assign bus.status_led  = status_led_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_alarm_control_fsm.sv
// Purpose: self-checking bench for alarm_control_fsm. A table of directed
// vectors (inputs plus hand-computed expected outputs after the next edge)
// is applied in order, followed by a status-LED tick sequence and a reset
// taken from the middle of an alarm cycle.
module tb_alarm_control_fsm;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  alarm_control_if bus_if ();

  alarm_control_fsm dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    logic       ign;
    logic       dd;
    logic       dp;
    logic       rp;
    logic [1:0] sel;
    logic [3:0] val;
    logic       ex;
    logic       hz;
    logic [2:0] e_state;
    logic       e_start;
    logic [3:0] e_tv;
    logic       e_siren;
    logic       e_led;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(input logic ign, input logic dd, input logic dp, input logic rp,
                             input logic [1:0] sel, input logic [3:0] val, input logic ex,
                             input logic hz, input logic [2:0] st, input logic start,
                             input logic [3:0] tv, input logic siren, input logic led);
    vec_t r;
    r.ign = ign; r.dd = dd; r.dp = dp; r.rp = rp; r.sel = sel; r.val = val;
    r.ex = ex; r.hz = hz; r.e_state = st; r.e_start = start; r.e_tv = tv;
    r.e_siren = siren; r.e_led = led;
    return r;
  endfunction

  task automatic check(input string name, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    bus_if.ignition      = x.ign;
    bus_if.door_driver   = x.dd;
    bus_if.door_pass     = x.dp;
    bus_if.reprogram     = x.rp;
    bus_if.prog_sel      = x.sel;
    bus_if.prog_val      = x.val;
    bus_if.expired       = x.ex;
    bus_if.one_hz_enable = x.hz;
  endtask

  task automatic check_outputs(input int idx, input vec_t x);
    $display("step %0d: ign=%0d dd=%0d dp=%0d rp=%0d ex=%0d hz=%0d -> state=%0d start=%0d tv=%0d siren=%0d led=%0d",
             idx, x.ign, x.dd, x.dp, x.rp, x.ex, x.hz, bus_if.state_dbg, bus_if.start_timer,
             bus_if.timer_value, bus_if.siren, bus_if.status_led);
    check("state_dbg",   idx, {1'b0, bus_if.state_dbg},   {1'b0, x.e_state});
    check("start_timer", idx, {3'b0, bus_if.start_timer}, {3'b0, x.e_start});
    check("timer_value", idx, bus_if.timer_value,         x.e_tv);
    check("siren",       idx, {3'b0, bus_if.siren},       {3'b0, x.e_siren});
    check("status_led",  idx, {3'b0, bus_if.status_led},  {3'b0, x.e_led});
  endtask

  task automatic apply(input int idx, input vec_t x);
    @(negedge clock);
    drive(x);
    @(posedge clock);
    #1;
    check_outputs(idx, x);
  endtask

  initial begin
    vec_t idle;
    logic led_model;

    idle = v(0,0,0,0,0,0,0,0, 0,0,0,0,0);
    drive(idle);

    //          ign dd dp rp sel val ex hz | st start tv siren led
    // T1: ARMED status LED ticks
    vecs.push_back(v(0,0,0,0,0,0,0,1, 0,0,0,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 0,0,0,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0,1, 0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,1, 0,0,0,0,1));
    // T2: driver door -> TRIGGER -> SOUND -> ARMED
    vecs.push_back(v(0,1,0,0,0,0,0,0, 1,1,8,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 1,0,8,0,1));
    vecs.push_back(v(0,0,0,0,0,0,1,0, 2,1,10,1,1));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 2,0,10,1,1));
    vecs.push_back(v(0,0,0,0,0,0,1,0, 0,0,10,0,0));
    // T3: both doors (driver wins), then disarm/arm cycle, passenger door
    vecs.push_back(v(0,1,1,0,0,0,0,0, 1,1,8,0,1));
    vecs.push_back(v(1,0,0,0,0,0,0,0, 3,0,8,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 4,0,8,0,0));
    vecs.push_back(v(0,1,0,0,0,0,0,0, 5,0,8,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 6,1,6,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 6,0,6,0,0));
    vecs.push_back(v(0,0,0,0,0,0,1,0, 0,0,6,0,0));
    vecs.push_back(v(0,0,1,0,0,0,0,0, 1,1,15,0,1));
    // T4: SOUND with passenger door held at expiry restarts the alarm interval
    vecs.push_back(v(0,0,0,0,0,0,0,0, 1,0,15,0,1));
    vecs.push_back(v(0,0,0,0,0,0,1,0, 2,1,10,1,1));
    vecs.push_back(v(0,0,1,0,0,0,0,0, 2,0,10,1,1));
    vecs.push_back(v(0,0,1,0,0,0,1,0, 2,1,10,1,1));
    vecs.push_back(v(0,0,0,0,0,0,1,0, 2,0,10,1,1));  // stale expired ignored
    vecs.push_back(v(0,0,0,0,0,0,1,0, 0,0,10,0,0));
    // T5: ignition in TRIGGER, arming interrupted by a door
    vecs.push_back(v(0,1,0,0,0,0,0,0, 1,1,8,0,1));
    vecs.push_back(v(1,0,0,0,0,0,0,0, 3,0,8,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 4,0,8,0,0));
    vecs.push_back(v(0,1,0,0,0,0,0,0, 5,0,8,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 6,1,6,0,0));
    vecs.push_back(v(0,0,1,0,0,0,0,0, 5,0,6,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 6,1,6,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 6,0,6,0,0));
    vecs.push_back(v(0,0,0,0,0,0,1,0, 0,0,6,0,0));
    // T6: reprogram from SOUND, zero write restores default, stale expired
    vecs.push_back(v(0,1,0,0,0,0,0,0, 1,1,8,0,1));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 1,0,8,0,1));
    vecs.push_back(v(0,0,0,0,0,0,1,0, 2,1,10,1,1));
    vecs.push_back(v(0,0,0,1,1,3,0,0, 0,0,10,0,0));
    vecs.push_back(v(0,1,0,0,0,0,0,0, 1,1,3,0,1));
    vecs.push_back(v(0,0,0,1,1,0,0,0, 0,0,3,0,0));
    vecs.push_back(v(0,1,0,0,0,0,0,0, 1,1,8,0,1));
    vecs.push_back(v(0,0,0,0,0,0,1,0, 1,0,8,0,1));
    vecs.push_back(v(0,0,0,0,0,0,1,0, 2,1,10,1,1));
    // reprogram beats ignition; DISARMED holds while ignition stays on
    vecs.push_back(v(1,0,0,1,3,0,0,0, 0,0,10,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0,0, 3,0,10,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0,0, 3,0,10,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 4,0,10,0,0));
    // reprogrammed arming delay used on the next arming load
    vecs.push_back(v(0,0,0,1,0,2,0,0, 0,0,10,0,0));
    vecs.push_back(v(1,0,0,0,0,0,0,0, 3,0,10,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 4,0,10,0,0));
    vecs.push_back(v(0,1,0,0,0,0,0,0, 5,0,10,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 6,1,2,0,0));
    vecs.push_back(v(0,0,0,0,0,0,0,0, 6,0,2,0,0));
    vecs.push_back(v(0,0,0,0,0,0,1,0, 0,0,2,0,0));

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check_outputs(0, idle);
    @(negedge clock);
    reset = 1'b0;

    foreach (vecs[i]) apply(i + 1, vecs[i]);

    // Status LED in ARMED over an irregular tick pattern
    led_model = 1'b0;
    for (int k = 0; k < 8; k++) begin
      vec_t t;
      t = idle;
      t.hz = ((k % 3) != 1);
      led_model = t.hz ? !led_model : led_model;
      t.e_tv  = 4'd2;
      t.e_led = led_model;
      apply(100 + k, t);
    end

    // Reset taken mid-alarm returns everything to the reset state
    begin
      vec_t t;
      t = idle;
      t.dd = 1'b1; t.e_state = 3'd1; t.e_start = 1'b1; t.e_tv = 4'd8; t.e_led = 1'b1;
      apply(200, t);
      @(negedge clock);
      drive(idle);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check_outputs(201, idle);
      @(negedge clock);
      reset = 1'b0;
      t = idle;
      t.dp = 1'b1; t.e_state = 3'd1; t.e_start = 1'b1; t.e_tv = 4'd15; t.e_led = 1'b1;
      apply(202, t);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
